uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one uart_tx serializer between NUM_REQ byte producers (debug, status, echo paths).
//   Round-robin grant per byte; a requester can lock the link for a multi-byte packet
//   (req_last=0) so bytes from different sources never interleave inside a message.
//   Drives tx_start/tx_data into uart_tx and sequences on its uart_tx_busy flag.
// PARAMETERS
//   NUM_REQ        4   number of requesters (>=2)
//   IDXW           2   width of owner index = $clog2(NUM_REQ)
//   BUSY_WAIT_MAX  15  cycles to wait for tx_busy rise after tx_start before timeout
// PORTS
//   clock        in   1          100MHz system clock
//   reset        in   1          synchronous, active-high reset
//   req          in   NUM_REQ    per-requester: byte valid, held until req_ack
//   req_last     in   NUM_REQ    per-requester: this byte ends its packet
//   req_data     in   8*NUM_REQ  byte i at [8*i+7:8*i], held stable until req_ack
//   req_ack      out  NUM_REQ    one-cycle pulse: byte i captured, may present next
//   tx_start     out  1          to uart_tx: one-cycle start pulse
//   tx_data      out  8          to uart_tx: byte, valid while tx_start high and after
//   tx_busy      in   1          from uart_tx_busy
//   owner        out  IDXW       index of last granted requester
//   locked       out  1          packet lock held by owner
//   timeout_err  out  1          one-cycle pulse: tx_busy never rose after tx_start
// BEHAVIOUR
//   Reset (sync, high): state=IDLE, req_ack=0, tx_start=0, tx_data=0, owner=NUM_REQ-1,
//     locked=0, timeout_err=0, wait counter=0. Reset mid-transfer abandons byte and lock.
//   FSM states:
//   IDLE: if tx_busy=0 and a candidate exists -> capture winner w: tx_data<=req_data[w],
//     tx_start<=1, req_ack[w]<=1, owner<=w, locked<=~req_last[w]; -> START.
//     Candidates: locked ? {owner} & req : req. None, or tx_busy=1 -> stay IDLE.
//   START (1 cycle, tx_start/req_ack high): clear both, counter<=0 -> WAIT_BUSY.
//   WAIT_BUSY: tx_busy=1 -> WAIT_DONE; else count; count==BUSY_WAIT_MAX-1 ->
//     timeout_err pulse, locked<=0, -> IDLE (byte is dropped, not retried).
//   WAIT_DONE: tx_busy=0 -> IDLE; else stay.
//   Round-robin: search starts at (owner+1) mod NUM_REQ, wraps; first set bit wins.
//     After reset requester 0 has top priority.
//   Lock: held from grant of a req_last=0 byte until grant of owner's req_last=1 byte;
//     while locked, other requesters are never acked even if owner's req is low.
//   Latency: req high in IDLE cycle T (tx_busy=0) -> tx_start & req_ack high in T+1.
//   Exactly one byte per tx_start; tx_start never asserted while tx_busy=1.
//   req_ack is one-hot or zero at all times; tx_data holds until next grant.
//   Requester dropping req before ack: no grant, no side effect.
// TESTING
//   Reset, req[0]=1 data 8'h41 last=1 -> next cycle tx_start=1, req_ack=4'b0001,
//     tx_data=8'h41; one 8N1 frame of 'A' on serial line; locked stays 0.
//   req=4'b0111 held, all last=1, each re-raised after ack -> grant order 0,1,2,0,1,2;
//     never two tx_start without intervening tx_busy high->low.
//   req[2] sends 'H','I' (last=0,1) while req[1] requests 'x' -> serial order H,I,x;
//     locked=1 between H and I; req_ack[1] only after I's grant.
//   tx_busy tied 0, req[3]=1 -> tx_start at T+1, timeout_err at T+1+BUSY_WAIT_MAX,
//     locked=0, back to IDLE; next req granted normally.
//   Assert reset while in WAIT_DONE with locked=1 -> next cycle all outputs at reset
//     values, owner=NUM_REQ-1; following req[0] granted first.
//   tx_busy held high externally with req pending -> no tx_start until tx_busy=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer between NUM_REQ byte producers.
// Grants one byte per frame and can hold a packet lock so multi-byte messages never interleave.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int IDXW          = 2,
  parameter int BUSY_WAIT_MAX = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IDXW-1:0]      owner,
  output logic                 locked,
  output logic                 timeout_err
);

  localparam int CNTW = $clog2(BUSY_WAIT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [IDXW-1:0]     owner_q, owner_d;
  logic                locked_q, locked_d;
  logic                timeout_err_q, timeout_err_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [CNTW-1:0]     cnt_inc;

  logic [NUM_REQ-1:0]  cand;
  logic                found;
  logic [IDXW-1:0]     win;
  logic [IDXW-1:0]     idx;

  // While locked only the owner may be granted; search begins just past the owner.
  always_comb begin
    cand = req;
    if (locked_q) begin
      cand = '0;
      cand[owner_q] = req[owner_q];
    end
    found = 1'b0;
    win   = owner_q;
    idx   = owner_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDXW'((int'(owner_q) + k) % NUM_REQ);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign cnt_inc = cnt_q + CNTW'(1);

  always_comb begin
    state_d       = state_q;
    req_ack_d     = '0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    owner_d       = owner_q;
    locked_d      = locked_q;
    timeout_err_d = 1'b0;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (!tx_busy && found) begin
          tx_data_d      = req_data[8*win +: 8];
          tx_start_d     = 1'b1;
          req_ack_d[win] = 1'b1;
          owner_d        = win;
          locked_d       = ~req_last[win];
          state_d        = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_inc == CNTW'(BUSY_WAIT_MAX - 1)) begin
          // Serializer never answered: drop the byte and release any packet lock.
          timeout_err_d = 1'b1;
          locked_d      = 1'b0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      req_ack_q     <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      owner_q       <= IDXW'(NUM_REQ - 1);
      locked_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_ack_q     <= req_ack_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      owner_q       <= owner_d;
      locked_q      <= locked_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign owner       = owner_q;
  assign locked      = locked_q;
  assign timeout_err = timeout_err_q;

endmodule
